// File: rtl/simple_comparator_pkg.sv
// Shared types and helpers for the registered magnitude comparator:
// the three-way result encoding and its mapping onto lt/eq/gt flags.
package simple_comparator_pkg;

  localparam int CMP_DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_result_e;

  // Returns {lt, eq, gt}; the unused encoding maps to all-clear.
  function automatic logic [2:0] cmp_to_flags(cmp_result_e result);
    logic [2:0] flags;
    case (result)
      CMP_LT:  flags = 3'b100;
      CMP_EQ:  flags = 3'b010;
      CMP_GT:  flags = 3'b001;
      default: flags = 3'b000;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/simple_comparator_slice.sv
// One bit of the MSB-first compare cascade: passes an upstream decision through,
// otherwise decides on the first differing bit.
import simple_comparator_pkg::*;

module simple_comparator_slice (
  input  logic        a_i,
  input  logic        b_i,
  input  logic        decided_in,
  input  cmp_result_e result_in,
  output logic        decided_out,
  output cmp_result_e result_out
);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    decided_out = decided_in;
    result_out  = result_in;
    if (!decided_in) begin
      if (a_i != b_i) begin
        decided_out = 1'b1;
        result_out  = a_i ? CMP_GT : CMP_LT;
      end else begin
        result_out  = CMP_EQ;
      end
    end
  end

endmodule

// File: rtl/simple_comparator.sv
// Registered WIDTH-bit magnitude comparator producing one-hot lt/eq/gt one cycle
// after in_valid. Define SIMPLE_COMPARATOR_SIGNED_EN to add the is_signed port.
import simple_comparator_pkg::*;

module simple_comparator #(
  parameter int WIDTH = CMP_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
`ifdef SIMPLE_COMPARATOR_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             out_valid
);

  logic [WIDTH-1:0] a_cmp;
  logic [WIDTH-1:0] b_cmp;
  cmp_result_e      final_result;

  // Flipping both sign bits maps two's complement order onto unsigned order.
  always_comb begin
    a_cmp = a;
    b_cmp = b;
`ifdef SIMPLE_COMPARATOR_SIGNED_EN
    if (is_signed) begin
      a_cmp[WIDTH-1] = ~a[WIDTH-1];
      b_cmp[WIDTH-1] = ~b[WIDTH-1];
    end
`endif
  end

  for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
    logic        up_decided;
    cmp_result_e up_result;
    logic        dn_decided;
    cmp_result_e dn_result;

    if (i == WIDTH - 1) begin : g_head
      assign up_decided = 1'b0;
      assign up_result  = CMP_EQ;
    end else begin : g_link
      assign up_decided = g_slice[i+1].dn_decided;
      assign up_result  = g_slice[i+1].dn_result;
    end

    simple_comparator_slice u_slice (
      .a_i         (a_cmp[i]),
      .b_i         (b_cmp[i]),
      .decided_in  (up_decided),
      .result_in   (up_result),
      .decided_out (dn_decided),
      .result_out  (dn_result)
    );
  end

  // No differing bit anywhere in the chain means the operands are equal.
  assign final_result = g_slice[0].dn_decided ? g_slice[0].dn_result : CMP_EQ;

  // NOTE: state registers use non-blocking assignments and clear on the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt        <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        {lt, eq, gt} <= cmp_to_flags(final_result);
      end
    end
  end

endmodule

// File: tb/tb_simple_comparator.sv
// Directed self-checking bench for simple_comparator (WIDTH=3) using a
// scoreboard queue of expected flag/valid values.
module tb_simple_comparator;

  localparam int W = 3;

`ifdef SIMPLE_COMPARATOR_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0] flags;
    logic       valid;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         in_valid;
  logic         is_signed;
  logic         lt;
  logic         eq;
  logic         gt;
  logic         out_valid;

  int         checks;
  int         failures;
  exp_t       sb[$];
  logic [2:0] last_flags;

  simple_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
`ifdef SIMPLE_COMPARATOR_SIGNED_EN
    .is_signed (is_signed),
`endif
    .lt        (lt),
    .eq        (eq),
    .gt        (gt),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer compare, sign-extending when signed.
  function automatic logic [2:0] model_flags(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                             input logic sgn);
    int va;
    int vb;
    va = int'(ma);
    vb = int'(mb);
    if (sgn && SIGNED_EN) begin
      if (ma[W-1]) va = va - (1 << W);
      if (mb[W-1]) vb = vb - (1 << W);
    end
    if (va < vb) return 3'b100;
    if (va > vb) return 3'b001;
    return 3'b010;
  endfunction

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Drive one cycle of stimulus, push the expectation, then score after the edge.
  task automatic step(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic v, input logic s);
    exp_t e;
    a         = ta;
    b         = tb_v;
    in_valid  = v;
    is_signed = s;
    if (v) last_flags = model_flags(ta, tb_v, s);
    sb.push_back('{flags: last_flags, valid: v});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(tag, {lt, eq, gt, out_valid}, {e.flags, e.valid});
    if (out_valid) check({tag, "_onehot"}, {3'b000, $onehot({lt, eq, gt})}, 4'b0001);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    last_flags = 3'b000;
    rst_n      = 1'b0;
    a          = 3'd5;
    b          = 3'd2;
    in_valid   = 1'b1;
    is_signed  = 1'b0;

    // Reset held with a valid input present: outputs stay clear.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", {lt, eq, gt, out_valid}, 4'b0000);
    end
    @(negedge clk);
    rst_n = 1'b1;

    step("idle_after_reset", 3'd0, 3'd7, 1'b0, 1'b0);
    step("lt_basic",   3'b001, 3'b011, 1'b1, 1'b0);
    step("eq_b2b",     3'b101, 3'b101, 1'b1, 1'b0);
    step("gt_b2b",     3'b101, 3'b010, 1'b1, 1'b0);
    step("hold_load",  3'd5,   3'd2,   1'b1, 1'b0);
    step("hold_idle",  3'd0,   3'd7,   1'b0, 1'b0);
    step("hold_idle2", 3'd7,   3'd0,   1'b0, 1'b0);
    step("lsb_only",   3'b110, 3'b111, 1'b1, 1'b0);
    step("eq_zero",    3'd0,   3'd0,   1'b1, 1'b0);
    step("eq_max",     3'd7,   3'd7,   1'b1, 1'b0);
    step("msb_decide", 3'b100, 3'b011, 1'b1, 1'b0);

    // Signed operands; without the signed build these must compare unsigned.
    step("signed_lt",  3'b101, 3'b010, 1'b1, 1'b1);
    step("unsigned_gt", 3'b101, 3'b010, 1'b1, 1'b0);
    step("signed_neg", 3'b111, 3'b100, 1'b1, 1'b1);
    step("signed_pos", 3'b011, 3'b100, 1'b1, 1'b1);

    // Asynchronous reset between edges while a result is valid.
    step("pre_reset",  3'd6,   3'd1,   1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {lt, eq, gt, out_valid}, 4'b0000);
    last_flags = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_gt", 3'd7, 3'd0, 1'b1, 1'b0);

    // A burst of random traffic with random gaps, scored by the model.
    for (int i = 0; i < 40; i++) begin
      step("random", W'($urandom_range(0, 7)), W'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
